// File: rtl/ctrl_unit_mc.sv
// ctrl_unit_mc: multicycle CPU control FSM with memory wait states, mult/div handshake and exceptions
module ctrl_unit_mc #(
    parameter int MEM_WAIT   = 2,
    parameter int RST_CYCLES = 1,
    parameter bit MD_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Overflow,
    input  logic       Negativo,
    input  logic       Zero,
    input  logic       EQ,
    input  logic       GT,
    input  logic       LT,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       md_done,
    output logic       pc_w,
    output logic [1:0] pc_src,
    output logic       mem_w,
    output logic       iord,
    output logic       ir_w,
    output logic       reg_w,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_ab_w,
    output logic       aluOut_w,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       md_start,
    output logic       md_op,
    output logic       epc_w,
    output logic [1:0] exc_code,
    output logic       rst_out,
    output logic [3:0] state_dbg
);
    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_WB, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
        S_WB_MEM, S_BRANCH, S_JUMP, S_JR, S_LUI, S_MD_START, S_MD_WAIT, S_EXC
    } state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] exc_q, exc_d;
    logic md_op_q, md_op_d;
    logic is_r, last, unused;
    assign is_r = opcode == 6'h00;
    assign last = cnt_q == 4'(MEM_WAIT);
    assign unused = Negativo ^ Zero;
    assign exc_code = exc_q;
    assign md_op = md_op_q;
    assign state_dbg = state_q;
    always_comb begin
        state_d = state_q;
        md_op_d = md_op_q;
        pc_w = 1'b0;
        pc_src = 2'd0;
        mem_w = 1'b0;
        iord = 1'b0;
        ir_w = 1'b0;
        reg_w = 1'b0;
        reg_dst = 2'd0;
        mem_to_reg = 2'd0;
        reg_ab_w = 1'b0;
        aluOut_w = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_op = 3'd0;
        md_start = 1'b0;
        epc_w = 1'b0;
        rst_out = 1'b0;
        case (state_q)
            S_RST: begin
                rst_out = 1'b1;
                state_d = cnt_q == 4'(RST_CYCLES - 1) ? S_FETCH : S_RST;
            end
            S_FETCH: begin
                ir_w = last;
                pc_w = last;
                alu_src_b = last ? 2'd1 : 2'd0;
                state_d = last ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                reg_ab_w = 1'b1;
                aluOut_w = 1'b1;
                alu_src_b = 2'd3;
                case (opcode)
                    6'h00: case (funct)
                        6'h20, 6'h22, 6'h24: state_d = S_EXEC;
                        6'h08: state_d = S_JR;
                        6'h18, 6'h1A: state_d = MD_EN ? S_MD_START : S_EXC;
                        default: state_d = S_EXC;
                    endcase
                    6'h08: state_d = S_EXEC;
                    6'h23, 6'h2B: state_d = S_MEM_ADDR;
                    6'h04, 6'h05, 6'h06, 6'h07: state_d = S_BRANCH;
                    6'h02, 6'h03: state_d = S_JUMP;
                    6'h0F: state_d = S_LUI;
                    default: state_d = S_EXC;
                endcase
                md_op_d = state_d == S_MD_START ? funct == 6'h1A : md_op_q;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = is_r ? 2'd0 : 2'd2;
                alu_op = !is_r ? 3'd0 : funct == 6'h22 ? 3'd1 : funct == 6'h24 ? 3'd2 : 3'd0;
                aluOut_w = 1'b1;
                state_d = Overflow && !(is_r && funct == 6'h24) ? S_EXC : S_WB;
            end
            S_WB: begin
                reg_w = 1'b1;
                reg_dst = is_r ? 2'd1 : 2'd0;
                state_d = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                aluOut_w = 1'b1;
                state_d = opcode == 6'h2B ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iord = 1'b1;
                state_d = last ? S_WB_MEM : S_MEM_RD;
            end
            S_MEM_WR: begin
                iord = 1'b1;
                mem_w = 1'b1;
                state_d = S_FETCH;
            end
            S_WB_MEM: begin
                reg_w = 1'b1;
                mem_to_reg = 2'd1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op = 3'd3;
                pc_src = 2'd1;
                pc_w = opcode[1] ? (opcode[0] ? GT : LT) : (opcode[0] ? !EQ : EQ);
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_src = 2'd2;
                pc_w = 1'b1;
                reg_w = opcode[0];
                reg_dst = opcode[0] ? 2'd2 : 2'd0;
                mem_to_reg = opcode[0] ? 2'd2 : 2'd0;
                state_d = S_FETCH;
            end
            S_JR: begin
                alu_src_a = 1'b1;
                pc_w = 1'b1;
                state_d = S_FETCH;
            end
            S_LUI: begin
                reg_w = 1'b1;
                mem_to_reg = 2'd3;
                state_d = S_FETCH;
            end
            S_MD_START: begin
                md_start = 1'b1;
                state_d = S_MD_WAIT;
            end
            S_MD_WAIT: state_d = md_done ? S_FETCH : S_MD_WAIT;
            S_EXC: begin
                epc_w = 1'b1;
                pc_src = 2'd3;
                pc_w = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_RST;
        endcase
        // cause is captured on entry so it is already visible while EXC writes EPC
        exc_d = state_d == S_EXC ? (state_q == S_DECODE ? 2'd1 : 2'd2) : exc_q;
        cnt_d = state_d == state_q ? cnt_q + 4'd1 : 4'd0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST;
            cnt_q <= 4'd0;
            exc_q <= 2'd0;
            md_op_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            exc_q <= exc_d;
            md_op_q <= md_op_d;
        end
    end
endmodule
